// File: rtl/card_pkg.sv
// Shared definitions for the card dealer and the game controller that consumes
// its cards: deck geometry, rank codes, LFSR defaults and the dealer FSM states.
package card_pkg;

    localparam int NUM_RANKS = 13;
    localparam int NUM_SUITS = 4;
    localparam int DECK_SIZE = NUM_RANKS * NUM_SUITS;

    // Face codes as presented on card_rank (J/Q/K count as half a point).
    localparam logic [3:0] RANK_A = 4'd1;
    localparam logic [3:0] RANK_J = 4'd11;
    localparam logic [3:0] RANK_Q = 4'd12;
    localparam logic [3:0] RANK_K = 4'd13;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form.
    localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] DEFAULT_LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } deal_state_e;

    // Fold a raw 4-bit random value into a 0-based rank (0..12).
    function automatic logic [3:0] fold_rank(input logic [3:0] raw);
        return (raw >= 4'(NUM_RANKS)) ? raw - 4'(NUM_RANKS) : raw;
    endfunction

    // Position of a (suit, 0-based rank) pair in the dealt-card mask.
    function automatic logic [5:0] card_index(input logic [1:0] suit,
                                              input logic [3:0] rank);
        return ({4'd0, suit} * 6'(NUM_RANKS)) + {2'd0, rank};
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Galois LFSR; advances on every clock and never stalls.
module card_lfsr #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter logic [15:0] LFSR_TAPS = 16'hB400
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Shift right, folding the taps back in when a one falls out of bit 0.
    always_comb begin
        state_d = state_q[0] ? ((state_q >> 1) ^ LFSR_TAPS) : (state_q >> 1);
    end

    // State register; a nonzero seed keeps the all-zero lock-up state unreachable.
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/card_dealer.sv
// Deals unique cards from a 52-card deck: a random probe pointer is taken from
// the LFSR, then walked forward one slot per cycle until an undealt card is hit.
module card_dealer
    import card_pkg::*;
#(
    parameter logic [15:0] SEED      = DEFAULT_LFSR_SEED,
    parameter logic [15:0] LFSR_TAPS = DEFAULT_LFSR_TAPS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       draw_req,
    input  logic       shuffle,
    output logic       card_valid,
    output logic [3:0] card_rank,
    output logic [1:0] card_suit,
    output logic       busy,
    output logic       deck_empty,
    output logic       empty_err,
    output logic [5:0] cards_left
);

    logic [15:0]          lfsr_state;
    logic                 lfsr_unused;

    deal_state_e          state_q,        state_d;
    logic [DECK_SIZE-1:0] used_q,         used_d;
    logic [5:0]           cards_left_q,   cards_left_d;
    logic [3:0]           probe_rank_q,   probe_rank_d;
    logic [1:0]           probe_suit_q,   probe_suit_d;
    logic [3:0]           card_rank_q,    card_rank_d;
    logic [1:0]           card_suit_q,    card_suit_d;
    logic                 empty_err_q,    empty_err_d;
    logic [5:0]           probe_idx;

    card_lfsr #(
        .SEED      (SEED),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .state_o (lfsr_state)
    );

    // Only the low six bits seed the probe; the rest just keep the sequence long.
    assign lfsr_unused = ^lfsr_state[15:6];

    assign probe_idx = card_index(probe_suit_q, probe_rank_q);

    // Next-state logic: shuffle overrides everything, draws are taken only when not scanning.
    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        used_d       = used_q;
        cards_left_d = cards_left_q;
        probe_rank_d = probe_rank_q;
        probe_suit_d = probe_suit_q;
        card_rank_d  = card_rank_q;
        card_suit_d  = card_suit_q;
        empty_err_d  = 1'b0;

        if (shuffle) begin
            used_d       = '0;
            cards_left_d = 6'(DECK_SIZE);
            state_d      = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_EMIT: begin
                    state_d = ST_IDLE;
                    if (draw_req) begin
                        if (deck_empty) begin
                            empty_err_d = 1'b1;
                        end else begin
                            probe_rank_d = fold_rank(lfsr_state[3:0]);
                            probe_suit_d = lfsr_state[5:4];
                            state_d      = ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (!used_q[probe_idx]) begin
                        used_d[probe_idx] = 1'b1;
                        cards_left_d      = cards_left_q - 6'd1;
                        card_rank_d       = probe_rank_q + 4'd1;
                        card_suit_d       = probe_suit_q;
                        state_d           = ST_EMIT;
                    end else if (probe_rank_q == 4'(NUM_RANKS - 1)) begin
                        // Suit wraps 3 -> 0 through the natural 2-bit overflow.
                        probe_rank_d = 4'd0;
                        probe_suit_d = probe_suit_q + 2'd1;
                    end else begin
                        probe_rank_d = probe_rank_q + 4'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Dealer state registers, all returned to a known deck on reset.
    // NOTE: the dealt-card mask is reset too; a deck of unknown contents would deal garbage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            used_q       <= '0;
            cards_left_q <= 6'(DECK_SIZE);
            probe_rank_q <= 4'd0;
            probe_suit_q <= 2'd0;
            card_rank_q  <= 4'd0;
            card_suit_q  <= 2'd0;
            empty_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            used_q       <= used_d;
            cards_left_q <= cards_left_d;
            probe_rank_q <= probe_rank_d;
            probe_suit_q <= probe_suit_d;
            card_rank_q  <= card_rank_d;
            card_suit_q  <= card_suit_d;
            empty_err_q  <= empty_err_d;
        end
    end

    assign card_valid = (state_q == ST_EMIT);
    assign busy       = (state_q == ST_SCAN);
    assign deck_empty = (cards_left_q == 6'd0);
    assign empty_err  = empty_err_q;
    assign cards_left = cards_left_q;
    assign card_rank  = card_rank_q;
    assign card_suit  = card_suit_q;

endmodule
